wic_wake_ctrl: RTL and testbench

WIC_WAKE_CTRL -- requirements
Module: wic_wake_ctrl

---
 rtl/wic_wake_ctrl.sv | 167 ++++++++++++++++
 tb/tb_wic_wake_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/wic_wake_ctrl.sv
// Wake-up interrupt controller sequencer: drains the CPU, gates its clock, and restores it on wake.
// Optional forced-wake timeout while sleeping is built when WIC_WAKE_TIMEOUT_EN is defined.
module wic_wake_ctrl #(
    parameter int GATE_DLY = 4,
    parameter int WAKE_DLY = 8,
    parameter int TIMEOUT  = 1024
) (
    input  logic       wic_clk,
    input  logic       pad_cpu_rst,
    input  logic       cpu_lpmd_req,
    input  logic       cpu_idle,
    input  logic       intraw_vld,
    output logic       cpu_clk_en,
    output logic       lpmd_ack,
    output logic       wake_done,
    output logic [1:0] wake_state,
    output logic       wake_cause
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DRAIN = 2'b01,
        ST_SLEEP = 2'b10,
        ST_WAKE  = 2'b11
    } state_t;

    localparam logic [7:0]  GATE_LAST = 8'(GATE_DLY - 1);
    localparam logic [7:0]  WAKE_LAST = 8'(WAKE_DLY - 1);

    if (GATE_DLY < 1 || GATE_DLY > 255) begin : g_bad_gate
        $error("GATE_DLY out of range 1..255");
    end
    if (WAKE_DLY < 1 || WAKE_DLY > 255) begin : g_bad_wake
        $error("WAKE_DLY out of range 1..255");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("TIMEOUT out of range 1..65535");
    end

    state_t     state_r, state_s;
    logic [7:0] cnt_r, cnt_s;
    logic       armed_r, armed_s;
    logic       cause_r, cause_s;
    logic       clk_en_r, clk_en_s;
    logic       ack_r, ack_s;
    logic       done_r, done_s;

`ifdef WIC_WAKE_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    logic [15:0] tcnt_r, tcnt_s;
`endif

    // Next-state, counter and registered-output decode
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        cause_s = cause_r;
`ifdef WIC_WAKE_TIMEOUT_EN
        tcnt_s  = tcnt_r;
`endif
        // A request still high after a wake must be released before it can re-arm
        if (!cpu_lpmd_req) begin
            armed_s = 1'b1;
        end else begin
            armed_s = armed_r;
        end

        case (state_r)
            ST_RUN: begin
                cnt_s = 8'd0;
                if (cpu_lpmd_req && armed_r && !intraw_vld) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (intraw_vld || !cpu_lpmd_req) begin
                    state_s = ST_RUN;
                    cnt_s   = 8'd0;
                end else if (cpu_idle) begin
                    if (cnt_r == GATE_LAST) begin
                        state_s = ST_SLEEP;
                        cnt_s   = 8'd0;
                        armed_s = 1'b0;
`ifdef WIC_WAKE_TIMEOUT_EN
                        tcnt_s  = 16'd0;
`endif
                    end else begin
                        cnt_s = cnt_r + 8'd1;
                    end
                end else begin
                    cnt_s = 8'd0;
                end
            end
            ST_SLEEP: begin
                if (intraw_vld) begin
                    state_s = ST_WAKE;
                    cnt_s   = 8'd0;
                    cause_s = 1'b0;
`ifdef WIC_WAKE_TIMEOUT_EN
                end else if (tcnt_r == TIMEOUT_LAST) begin
                    state_s = ST_WAKE;
                    cnt_s   = 8'd0;
                    cause_s = 1'b1;
                end else begin
                    tcnt_s  = tcnt_r + 16'd1;
                end
`else
                end else begin
                    state_s = ST_SLEEP;
                end
`endif
            end
            ST_WAKE: begin
                if (cnt_r == WAKE_LAST) begin
                    state_s = ST_RUN;
                    cnt_s   = 8'd0;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            default: begin
                state_s = ST_RUN;
                cnt_s   = 8'd0;
            end
        endcase

        clk_en_s = (state_s == ST_RUN) || (state_s == ST_DRAIN);
        ack_s    = (state_s == ST_SLEEP) && (state_r != ST_SLEEP);
        done_s   = (state_s == ST_RUN) && (state_r == ST_WAKE);
    end

    // State, counters and outputs register with synchronous reset
    always_ff @(posedge wic_clk) begin
        if (pad_cpu_rst) begin
            state_r  <= ST_RUN;
            cnt_r    <= 8'd0;
            armed_r  <= 1'b1;
            cause_r  <= 1'b0;
            clk_en_r <= 1'b1;
            ack_r    <= 1'b0;
            done_r   <= 1'b0;
`ifdef WIC_WAKE_TIMEOUT_EN
            tcnt_r   <= 16'd0;
`endif
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            armed_r  <= armed_s;
            cause_r  <= cause_s;
            clk_en_r <= clk_en_s;
            ack_r    <= ack_s;
            done_r   <= done_s;
`ifdef WIC_WAKE_TIMEOUT_EN
            tcnt_r   <= tcnt_s;
`endif
        end
    end

    assign wake_state = state_r;
    assign cpu_clk_en = clk_en_r;
    assign lpmd_ack   = ack_r;
    assign wake_done  = done_r;
    assign wake_cause = cause_r;

endmodule

// File: tb/tb_wic_wake_ctrl.sv
// Directed bench for wic_wake_ctrl: sleep entry, drain abort, wake latency, re-arm and reset.
module tb_wic_wake_ctrl;

    localparam logic [1:0] S_RUN   = 2'b00;
    localparam logic [1:0] S_DRAIN = 2'b01;
    localparam logic [1:0] S_SLEEP = 2'b10;
    localparam logic [1:0] S_WAKE  = 2'b11;

    logic       wic_clk = 1'b0;
    logic       pad_cpu_rst;
    logic       cpu_lpmd_req;
    logic       cpu_idle;
    logic       intraw_vld;
    logic       cpu_clk_en;
    logic       lpmd_ack;
    logic       wake_done;
    logic [1:0] wake_state;
    logic       wake_cause;

    int n_tests = 0;
    int n_fail  = 0;

    wic_wake_ctrl #(
        .GATE_DLY(4),
        .WAKE_DLY(8),
        .TIMEOUT (16)
    ) dut (
        .wic_clk     (wic_clk),
        .pad_cpu_rst (pad_cpu_rst),
        .cpu_lpmd_req(cpu_lpmd_req),
        .cpu_idle    (cpu_idle),
        .intraw_vld  (intraw_vld),
        .cpu_clk_en  (cpu_clk_en),
        .lpmd_ack    (lpmd_ack),
        .wake_done   (wake_done),
        .wake_state  (wake_state),
        .wake_cause  (wake_cause)
    );

    always #5 wic_clk = ~wic_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge wic_clk);
            #1;
        end
    endtask

    // From RUN: release and re-raise the request, then drain with continuous idle into SLEEP
    task automatic go_sleep(input string tag);
        cpu_lpmd_req = 1'b0;
        cpu_idle     = 1'b1;
        intraw_vld   = 1'b0;
        step(1);
        cpu_lpmd_req = 1'b1;
        step(1);
        check_val({tag, "_drain"}, {30'd0, wake_state}, {30'd0, S_DRAIN});
        step(4);
        check_val({tag, "_sleep"}, {30'd0, wake_state}, {30'd0, S_SLEEP});
        check_val({tag, "_ack"}, {31'd0, lpmd_ack}, 32'd1);
    endtask

    initial begin
        pad_cpu_rst  = 1'b1;
        cpu_lpmd_req = 1'b0;
        cpu_idle     = 1'b0;
        intraw_vld   = 1'b0;
        step(2);
        pad_cpu_rst  = 1'b0;
        check_val("rst_state", {30'd0, wake_state}, {30'd0, S_RUN});
        check_val("rst_clken", {31'd0, cpu_clk_en}, 32'd1);
        check_val("rst_ack", {31'd0, lpmd_ack}, 32'd0);
        check_val("rst_done", {31'd0, wake_done}, 32'd0);
        check_val("rst_cause", {31'd0, wake_cause}, 32'd0);

        // Basic sleep entry and wake latency
        cpu_lpmd_req = 1'b1;
        cpu_idle     = 1'b1;
        step(1);
        check_val("basic_drain", {30'd0, wake_state}, {30'd0, S_DRAIN});
        check_val("basic_drain_clk", {31'd0, cpu_clk_en}, 32'd1);
        step(3);
        check_val("basic_still_drain", {30'd0, wake_state}, {30'd0, S_DRAIN});
        check_val("basic_no_ack", {31'd0, lpmd_ack}, 32'd0);
        step(1);
        check_val("basic_sleep", {30'd0, wake_state}, {30'd0, S_SLEEP});
        check_val("basic_ack", {31'd0, lpmd_ack}, 32'd1);
        check_val("basic_clk_off", {31'd0, cpu_clk_en}, 32'd0);
        step(1);
        check_val("basic_ack_pulse", {31'd0, lpmd_ack}, 32'd0);
        step(10);
        intraw_vld = 1'b1;
        step(1);
        intraw_vld = 1'b0;
        check_val("basic_wake", {30'd0, wake_state}, {30'd0, S_WAKE});
        check_val("basic_wake_clk", {31'd0, cpu_clk_en}, 32'd0);
        step(7);
        check_val("basic_wake_hold", {30'd0, wake_state}, {30'd0, S_WAKE});
        check_val("basic_wake_hold_clk", {31'd0, cpu_clk_en}, 32'd0);
        check_val("basic_no_done", {31'd0, wake_done}, 32'd0);
        step(1);
        check_val("basic_run", {30'd0, wake_state}, {30'd0, S_RUN});
        check_val("basic_clk_on", {31'd0, cpu_clk_en}, 32'd1);
        check_val("basic_done", {31'd0, wake_done}, 32'd1);
        check_val("basic_cause", {31'd0, wake_cause}, 32'd0);

        // Request held across wake must not re-enter until released
        step(1);
        check_val("hold_done_pulse", {31'd0, wake_done}, 32'd0);
        step(5);
        check_val("hold_no_reentry", {30'd0, wake_state}, {30'd0, S_RUN});
        cpu_lpmd_req = 1'b0;
        step(1);
        check_val("hold_released", {30'd0, wake_state}, {30'd0, S_RUN});
        cpu_lpmd_req = 1'b1;
        step(1);
        check_val("hold_rearm_drain", {30'd0, wake_state}, {30'd0, S_DRAIN});

        // Idle drop inside DRAIN restarts the gate count
        step(2);
        cpu_idle = 1'b0;
        step(1);
        check_val("idle_drop_drain", {30'd0, wake_state}, {30'd0, S_DRAIN});
        cpu_idle = 1'b1;
        step(3);
        check_val("idle_reassert_drain", {30'd0, wake_state}, {30'd0, S_DRAIN});
        step(1);
        check_val("idle_reassert_sleep", {30'd0, wake_state}, {30'd0, S_SLEEP});
        check_val("idle_reassert_ack", {31'd0, lpmd_ack}, 32'd1);
        intraw_vld = 1'b1;
        step(1);
        intraw_vld = 1'b0;
        step(8);
        check_val("idle_wake_done", {31'd0, wake_done}, 32'd1);

        // Interrupt and request-drop aborts in DRAIN; interrupt blocks RUN exit
        cpu_lpmd_req = 1'b0;
        step(1);
        cpu_lpmd_req = 1'b1;
        step(1);
        check_val("abort_irq_drain", {30'd0, wake_state}, {30'd0, S_DRAIN});
        intraw_vld = 1'b1;
        step(1);
        check_val("abort_irq_run", {30'd0, wake_state}, {30'd0, S_RUN});
        check_val("abort_irq_no_ack", {31'd0, lpmd_ack}, 32'd0);
        step(2);
        check_val("irq_blocks_run", {30'd0, wake_state}, {30'd0, S_RUN});
        intraw_vld = 1'b0;
        step(1);
        check_val("abort_req_drain", {30'd0, wake_state}, {30'd0, S_DRAIN});
        step(2);
        cpu_lpmd_req = 1'b0;
        step(1);
        check_val("abort_req_run", {30'd0, wake_state}, {30'd0, S_RUN});
        check_val("abort_req_no_ack", {31'd0, lpmd_ack}, 32'd0);

        // Reset in WAKE at counter 3
        go_sleep("rstw");
        intraw_vld = 1'b1;
        step(1);
        intraw_vld = 1'b0;
        step(3);
        check_val("rstw_in_wake", {30'd0, wake_state}, {30'd0, S_WAKE});
        cpu_lpmd_req = 1'b0;
        pad_cpu_rst  = 1'b1;
        step(1);
        pad_cpu_rst  = 1'b0;
        check_val("rstw_state", {30'd0, wake_state}, {30'd0, S_RUN});
        check_val("rstw_clken", {31'd0, cpu_clk_en}, 32'd1);
        check_val("rstw_done", {31'd0, wake_done}, 32'd0);
        step(1);
        check_val("rstw_done_after", {31'd0, wake_done}, 32'd0);

        // Reset in SLEEP
        go_sleep("rsts");
        step(2);
        pad_cpu_rst = 1'b1;
        step(1);
        pad_cpu_rst = 1'b0;
        cpu_lpmd_req = 1'b0;
        check_val("rsts_state", {30'd0, wake_state}, {30'd0, S_RUN});
        check_val("rsts_clken", {31'd0, cpu_clk_en}, 32'd1);
        check_val("rsts_done", {31'd0, wake_done}, 32'd0);

`ifdef WIC_WAKE_TIMEOUT_EN
        // Forced wake after 16 sleep cycles, then interrupt winning on the 16th
        go_sleep("to");
        step(15);
        check_val("to_still_sleep", {30'd0, wake_state}, {30'd0, S_SLEEP});
        step(1);
        check_val("to_wake", {30'd0, wake_state}, {30'd0, S_WAKE});
        check_val("to_cause", {31'd0, wake_cause}, 32'd1);
        step(8);
        check_val("to_done", {31'd0, wake_done}, 32'd1);
        check_val("to_cause_hold", {31'd0, wake_cause}, 32'd1);
        go_sleep("toi");
        step(15);
        intraw_vld = 1'b1;
        step(1);
        intraw_vld = 1'b0;
        check_val("toi_wake", {30'd0, wake_state}, {30'd0, S_WAKE});
        check_val("toi_cause", {31'd0, wake_cause}, 32'd0);
        step(8);
        check_val("toi_done", {31'd0, wake_done}, 32'd1);
`else
        // Without the timeout, SLEEP is held indefinitely
        go_sleep("nto");
        step(40);
        check_val("nto_sleep", {30'd0, wake_state}, {30'd0, S_SLEEP});
        check_val("nto_cause", {31'd0, wake_cause}, 32'd0);
        intraw_vld = 1'b1;
        step(1);
        intraw_vld = 1'b0;
        step(8);
        check_val("nto_done", {31'd0, wake_done}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
